iodelay_tap_ctrl: RTL
=====================

Name: iodelay_tap_ctrl

Overview:
Multi-channel IDELAY tap controller, the parametrised successor of the single-channel gate-path delay FSM. It sequences the IDELAYCTRL reset, waits for RDY with a timeout, and steps or loads taps on NCH IDELAYE3 instances. Taps are adjusted on a sampling-trigger rising edge or an explicit load request, and a shadow tap count per channel is kept for readback. It sits between the calibration DIP-switch/trigger logic and the IDELAYCTRL/IDELAYE3 primitives.

Parameters:
NCH, 4, number of delay channels (1..16)
TAP_W, 9, tap counter width; max tap = 2^TAP_W-1
RST_CYC, 16, cycles ctrl_rst is held high (>=2)
RDY_TO, 1023, cycles to wait for dly_rdy before error (>=1)
SETTLE_CYC, 4, idle cycles after any CE/LOAD before next operation (>=1)

Ports:
clk  in  1  controller clock; also drives IDELAYE3 CLK
resetn  in  1  asynchronous active-low reset
sampling_trig  in  1  step request; acts on 0->1 edge only
calib_en  in  1  enables trigger-driven steps (DIP switch, pre-synchronised)
ch_sel  in  $clog2(NCH) (min 1)  target channel, sampled when an operation is accepted
load_req  in  1  one-cycle request to load load_val into ch_sel
load_val  in  TAP_W  tap value for load
dly_rdy  in  1  IDELAYCTRL RDY, pre-synchronised to clk
ctrl_rst  out  1  IDELAYCTRL RST and IDELAYE3 RST
dly_ce  out  NCH  one-hot CE pulse
dly_inc  out  1  INC to all channels
dly_load  out  NCH  one-hot LOAD pulse
dly_cntvaluein  out  TAP_W  CNTVALUEIN shared by all channels
tap_count  out  NCH*TAP_W  shadow tap per channel; channel i at [i*TAP_W +: TAP_W]
ready  out  1  high in IDLE only
busy  out  1  high in STEP/LOAD/SETTLE
err_timeout  out  1  sticky; set on RDY timeout

Behaviour:
- Reset (resetn low, async): state=RST_CTRL, ctrl_rst=1, dly_ce=0, dly_load=0, dly_inc=1, dly_cntvaluein=0, all tap_count=0, ready=0, busy=0, err_timeout=0, edge register=0, counters=0.
- RST_CTRL: ctrl_rst=1 for exactly RST_CYC cycles after reset release, then -> WAIT_RDY with ctrl_rst=0.
- WAIT_RDY: dly_rdy=1 -> IDLE. If RDY_TO cycles elapse without it -> ERR.
- ERR: err_timeout=1; all outputs idle. Leaves only on resetn.
- IDLE: ready=1. Priority: load_req > trigger edge (sampling_trig=1, previous=0, calib_en=1). Accepted op latches ch_sel.
  - If dly_rdy drops in IDLE -> WAIT_RDY; taps retained.
- STEP: one cycle. If tap<max: dly_ce[ch]=1, dly_inc=1, tap+1. If tap==max: wrap via dly_load[ch]=1, dly_cntvaluein=0, tap=0. -> SETTLE.
- LOAD: one cycle. dly_load[ch]=1, dly_cntvaluein=load_val, tap=load_val. -> SETTLE.
- SETTLE: SETTLE_CYC cycles, all strobes 0 -> IDLE.
- Latency: an edge seen in IDLE at cycle N produces dly_ce at N+1 and ready at N+2+SETTLE_CYC.
- Requests arriving outside IDLE are dropped, not queued. The edge register updates every cycle, so a trigger held high across the return to IDLE does not re-fire.
- ch_sel >= NCH: the request is ignored and the FSM stays in IDLE.
- dly_ce and dly_load are never high together and are never high on more than one bit.

Optional Feature:
IODELAY_DEC_EN:
- Defined: adds input step_dir (1=inc, 0=dec), sampled with ch_sel. Decrement drives dly_inc=0 with CE; a decrement at tap 0 wraps via LOAD to max.
- Undefined: the port is absent and dly_inc is tied 1.

Decomposition:
- Package iodelay_pkg holds the state enum (RST_CTRL, WAIT_RDY, IDLE, STEP, LOAD, SETTLE, ERR) and a TAP_MAX helper function.
- One sub-module, iodelay_edge_det, provides the registered rising-edge detector with an async-low reset.

Test Plan:
- Reset release -> ctrl_rst high exactly 16 cycles. dly_rdy raised 5 cycles later -> ready=1 on the next cycle.
- dly_rdy never asserted -> err_timeout=1 after 1023 cycles in WAIT_RDY. It stays high until resetn pulses.
- calib_en=1, ch_sel=2, three trigger edges spaced 10 cycles apart -> three single dly_ce[2] pulses and tap_count ch2=3, with other channels at 0. calib_en=0 -> no pulse.
- load_req with load_val=511 on ch 1, then one edge -> dly_load[1] with cntvaluein 0 and tap=0 (wrap).
- load_req and trigger edge in the same cycle -> only the LOAD is executed. The edge is dropped.
- dly_rdy dropped in IDLE -> ready=0, state WAIT_RDY, taps retained. Restoring dly_rdy -> back to IDLE.

Source files
------------

// File: rtl/iodelay_pkg.sv
// iodelay_pkg: FSM state encoding and tap-range helper shared by the IDELAY tap controller
package iodelay_pkg;
  typedef enum logic [2:0] {RST_CTRL, WAIT_RDY, IDLE, STEP, LOAD, SETTLE, ERR} state_t;
  function automatic int unsigned tap_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction
endpackage

// File: rtl/iodelay_tap_ctrl_if.sv
// iodelay_tap_ctrl_if: calibration-side requests and IDELAYCTRL/IDELAYE3 controls for iodelay_tap_ctrl
//   master: the tap controller (drives ctrl_rst, dly_*, tap_count, ready, busy, err_timeout)
//   slave : calibration logic and delay primitives (drive trigger, calib_en, ch_sel, load_*, dly_rdy)
//   step_dir exists only when IODELAY_DEC_EN is defined
interface iodelay_tap_ctrl_if #(parameter int NCH = 4, parameter int TAP_W = 9);
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  logic                 sampling_trig;
  logic                 calib_en;
  logic [CW-1:0]        ch_sel;
  logic                 load_req;
  logic [TAP_W-1:0]     load_val;
  logic                 dly_rdy;
`ifdef IODELAY_DEC_EN
  logic                 step_dir;
`endif
  logic                 ctrl_rst;
  logic [NCH-1:0]       dly_ce;
  logic                 dly_inc;
  logic [NCH-1:0]       dly_load;
  logic [TAP_W-1:0]     dly_cntvaluein;
  logic [NCH*TAP_W-1:0] tap_count;
  logic                 ready;
  logic                 busy;
  logic                 err_timeout;
  modport master (
    input  sampling_trig, calib_en, ch_sel, load_req, load_val, dly_rdy,
`ifdef IODELAY_DEC_EN
    input  step_dir,
`endif
    output ctrl_rst, dly_ce, dly_inc, dly_load, dly_cntvaluein, tap_count, ready, busy, err_timeout
  );
  modport slave (
    output sampling_trig, calib_en, ch_sel, load_req, load_val, dly_rdy,
`ifdef IODELAY_DEC_EN
    output step_dir,
`endif
    input  ctrl_rst, dly_ce, dly_inc, dly_load, dly_cntvaluein, tap_count, ready, busy, err_timeout
  );
endinterface

// File: rtl/iodelay_edge_det.sv
// iodelay_edge_det: registered rising-edge detector
//   clk, resetn (async active-low), i_d level input, o_rise high while i_d=1 and last sample was 0
module iodelay_edge_det (
  input  logic clk,
  input  logic resetn,
  input  logic i_d,
  output logic o_rise
);
  logic r_prev;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_prev <= 1'b0;
    else         r_prev <= i_d;
  assign o_rise = i_d & ~r_prev;
endmodule

// File: rtl/iodelay_tap_ctrl.sv
// iodelay_tap_ctrl: multi-channel IDELAYCTRL reset/RDY sequencer and IDELAYE3 tap stepper/loader
//   clk, resetn (async active-low); bus: iodelay_tap_ctrl_if.master carrying requests and primitive controls
//   optional IODELAY_DEC_EN adds bus.step_dir (1=inc, 0=dec); otherwise dly_inc is always 1
module iodelay_tap_ctrl
  import iodelay_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int TAP_W      = 9,
  parameter int RST_CYC    = 16,
  parameter int RDY_TO     = 1023,
  parameter int SETTLE_CYC = 4
) (
  input  logic clk,
  input  logic resetn,
  iodelay_tap_ctrl_if.master bus
);
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int CN = 1 << CW;
  localparam logic [TAP_W-1:0] MAX = TAP_W'(tap_max(TAP_W));
  // one bit per encodable ch_sel value; avoids a constant compare when NCH is a power of two
  localparam logic [CN-1:0] VALID = CN'((64'd1 << NCH) - 64'd1);
  state_t r_state, w_next;
  logic [31:0] r_cnt;
  logic [CW-1:0] r_ch;
  logic [TAP_W-1:0] r_val;
  logic r_dir;
  logic [TAP_W-1:0] r_tap [NCH];
  logic [TAP_W-1:0] w_cur;
  logic [NCH-1:0] w_hot;
  logic w_rise, w_ok, w_ld, w_st, w_dir, w_wrap;
  iodelay_edge_det u_edge (.clk(clk), .resetn(resetn), .i_d(bus.sampling_trig), .o_rise(w_rise));
`ifdef IODELAY_DEC_EN
  assign w_dir = bus.step_dir;
`else
  assign w_dir = 1'b1;
`endif
  // a step that would leave the tap range is turned into a LOAD of the opposite end
  always_comb begin
    w_ok   = VALID[bus.ch_sel];
    w_ld   = bus.load_req & w_ok;
    w_st   = ~bus.load_req & w_rise & bus.calib_en & w_ok;
    w_cur  = r_tap[bus.ch_sel];
    w_wrap = w_dir ? w_cur == MAX : w_cur == '0;
    w_next = r_state;
    case (r_state)
      RST_CTRL: w_next = r_cnt == 32'(RST_CYC - 1) ? WAIT_RDY : RST_CTRL;
      WAIT_RDY: w_next = bus.dly_rdy ? IDLE : r_cnt == 32'(RDY_TO - 1) ? ERR : WAIT_RDY;
      IDLE:     w_next = !bus.dly_rdy ? WAIT_RDY : (w_ld || (w_st && w_wrap)) ? LOAD : w_st ? STEP : IDLE;
      STEP:     w_next = SETTLE;
      LOAD:     w_next = SETTLE;
      SETTLE:   w_next = r_cnt == 32'(SETTLE_CYC - 1) ? IDLE : SETTLE;
      default:  w_next = r_state;
    endcase
  end
  always_comb begin
    w_hot              = NCH'(1) << r_ch;
    bus.ctrl_rst       = r_state == RST_CTRL;
    bus.ready          = r_state == IDLE;
    bus.busy           = r_state inside {STEP, LOAD, SETTLE};
    bus.err_timeout    = r_state == ERR;
    bus.dly_ce         = r_state == STEP ? w_hot : '0;
    bus.dly_load       = r_state == LOAD ? w_hot : '0;
    bus.dly_inc        = !(r_state == STEP && !r_dir);
    bus.dly_cntvaluein = r_val;
    bus.tap_count      = '0;
    for (int i = 0; i < NCH; i++) bus.tap_count[i*TAP_W +: TAP_W] = r_tap[i];
  end
  // the counter restarts on every state change, so each timed state counts from zero
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_state <= RST_CTRL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_next != r_state ? '0 : r_cnt + 32'd1;
    end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_ch  <= '0;
      r_val <= '0;
      r_dir <= 1'b1;
      for (int i = 0; i < NCH; i++) r_tap[i] <= '0;
    end else begin
      if (r_state == IDLE && (w_next == LOAD || w_next == STEP)) begin
        r_ch  <= bus.ch_sel;
        r_val <= w_ld ? bus.load_val : w_dir ? '0 : MAX;
        r_dir <= w_dir;
      end
      if (r_state == STEP) r_tap[r_ch] <= r_dir ? r_tap[r_ch] + TAP_W'(1) : r_tap[r_ch] - TAP_W'(1);
      if (r_state == LOAD) r_tap[r_ch] <= r_val;
    end
endmodule
